// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
//
// Contents:
//   RF_DATA_W / RF_ADDR_W / RF_SIDE_W : default widths used as parameter defaults
//   RF_ZERO_IDX                        : index of the hardwired zero register
//   rf_state_t                         : controller state (clear sweep / normal run)
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_SIDE_W   = 4;
  localparam int RF_ZERO_IDX = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the multiport register file.
//
// Selects one register from the flattened storage, applies the zero-register
// rule, optionally forwards the write being committed on the same edge, and
// captures the result in a stall-gated output register.
//
// Build option: REGFILE_BYPASS_EN -- when defined, a write to the address
// being read on the same edge is returned (write-first); otherwise the
// pre-write value is returned (read-first).
//
// Ports:
//   clock_i, reset_i : rising-edge clock, synchronous active-high reset
//   clear_i          : 1 while the storage clear sweep runs; output forced to 0
//   stall_i          : 1 = hold the output register
//   rd_addr_i        : register to read
//   regs_i           : flattened storage, register i at [i*DATA_W +: DATA_W]
//   wr_en_i          : a write is committed this edge (x0 drops already removed)
//   wr_addr_i        : address of that write
//   wr_data_i        : data of that write
//   rd_data_o        : registered read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = 2 ** RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    stall_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  input  logic [DEPTH*DATA_W-1:0] regs_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  output logic [DATA_W-1:0]       rd_data_o
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              is_zero;
  logic              bypass_hit;

  assign is_zero    = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(RF_ZERO_IDX));
  assign bypass_hit = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);

  // Zero register wins over everything, then the same-edge write, then storage.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        rd_data_d = regs_i[i*DATA_W +: DATA_W];
      end
    end
    if (bypass_hit) begin
      rd_data_d = wr_data_i;
    end
    if (is_zero) begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      rd_data_q <= '0;
    end else if (!stall_i) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file at the ID/EX boundary of the 5-stage pipeline.
//
// NUM_RD registered read ports, one write port, an independent registered
// debug read port, and an ALU-control sideband registered alongside the read
// data. After reset the controller sweeps every register to zero (init_busy=1)
// before accepting writes.
//
// Build option: REGFILE_BYPASS_EN (see regfile_read_port) selects write-first
// reads on a same-edge address match; undefined gives read-first.
//
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   stall              : 1 = hold rd_data and side_out (writes still commit)
//   wr_en/addr/data    : write port
//   rd_addr / rd_data  : packed read ports, port k at [k*W +: W]
//   side_in / side_out : ALU control, registered with rd_data
//   dbg_addr/dbg_data  : read-first debug port, ignores stall
//   init_busy          : 1 while the clear sweep runs (exposes controller state)
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int SIDE_W   = RF_SIDE_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [SIDE_W-1:0]        side_in,
  output logic [SIDE_W-1:0]        side_out,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_t              state_q, state_d;
  logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]      regs_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] regs_flat;
  logic                   clearing;
  logic                   wr_commit;
  logic [SIDE_W-1:0]      side_q;
  logic [DATA_W-1:0]      dbg_d;
  logic [DATA_W-1:0]      dbg_q;

  // ---------------- controller: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------- controller: next state ----------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_CLEAR;
    endcase
  end

  // ---------------- controller: outputs ----------------
  // x0 writes are filtered here so the read ports never forward a dropped write.
  always_comb begin
    clearing  = (state_q == RF_CLEAR);
    init_busy = clearing;
    wr_commit = (state_q == RF_RUN) && wr_en &&
                !((ZERO_REG != 0) && (wr_addr == ADDR_W'(RF_ZERO_IDX)));
  end

  // ---------------- storage ----------------
  // Not reset directly: the sweep clears one register per cycle instead.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clearing) begin
        regs_q[clr_cnt_q] <= '0;
      end else if (wr_commit) begin
        regs_q[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clock_i   (clock),
      .reset_i   (reset),
      .clear_i   (clearing),
      .stall_i   (stall),
      .rd_addr_i (rd_addr[k*ADDR_W +: ADDR_W]),
      .regs_i    (regs_flat),
      .wr_en_i   (wr_commit),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[k*DATA_W +: DATA_W])
    );
  end

  // ---------------- sideband ----------------
  always_ff @(posedge clock) begin
    if (reset || clearing) begin
      side_q <= '0;
    end else if (!stall) begin
      side_q <= side_in;
    end
  end

  assign side_out = side_q;

  // ---------------- debug port: always read-first, ignores stall ----------------
  always_comb begin
    dbg_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dbg_addr == ADDR_W'(i)) begin
        dbg_d = regs_q[i];
      end
    end
    if ((ZERO_REG != 0) && (dbg_addr == ADDR_W'(RF_ZERO_IDX))) begin
      dbg_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clearing) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= dbg_d;
    end
  end

  assign dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (default parameters).
// The driver applies inputs #1 after a rising edge, steps one edge, then
// queues the values the outputs must show after that edge. The monitor
// compares queued entries on the falling edge of the cycle they are due.
`timescale 1ns/1ps
module tb_regfile_multiport;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int SIDE_W = 4;

  localparam int SEL_RD0  = 0;
  localparam int SEL_RD1  = 1;
  localparam int SEL_SIDE = 2;
  localparam int SEL_DBG  = 3;
  localparam int SEL_BUSY = 4;

  // ---------------- clock / reset ----------------
  logic                     clock = 1'b0;
  logic                     reset;
  logic                     stall;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [SIDE_W-1:0]        side_in;
  logic [SIDE_W-1:0]        side_out;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;
  logic                     init_busy;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  regfile_multiport dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .side_in   (side_in),
    .side_out  (side_out),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .init_busy (init_busy)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  int                exp_sel_q[$];
  int                checks   = 0;
  int                failures = 0;
  string             sel_name [5] = '{"rd_data0", "rd_data1", "side_out", "dbg_data", "init_busy"};

  function automatic logic [DATA_W-1:0] actual(input int sel);
    case (sel)
      SEL_RD0:  return rd_data[DATA_W-1:0];
      SEL_RD1:  return rd_data[2*DATA_W-1:DATA_W];
      SEL_SIDE: return DATA_W'(side_out);
      SEL_DBG:  return dbg_data;
      default:  return DATA_W'(init_busy);
    endcase
  endfunction

  logic [DATA_W-1:0] mon_exp;
  logic [DATA_W-1:0] mon_act;
  int                mon_cyc;
  int                mon_sel;

  always @(negedge clock) begin
    while (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
      mon_exp = exp_q.pop_front();
      mon_cyc = exp_cyc_q.pop_front();
      mon_sel = exp_sel_q.pop_front();
      mon_act = actual(mon_sel);
      checks++;
      if (mon_cyc != cyc) begin
        failures++;
        $display("FAIL %s: due at cycle %0d, seen at cycle %0d", sel_name[mon_sel], mon_cyc, cyc);
      end else if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL %s @cycle %0d: got %h expected %h", sel_name[mon_sel], cyc, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [DATA_W-1:0] val);
    exp_q.push_back(val);
    exp_cyc_q.push_back(cyc);
    exp_sel_q.push_back(sel);
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic expect_reset_state();
    expect_out(SEL_BUSY, 1);
    expect_out(SEL_RD0, 0);
    expect_out(SEL_RD1, 0);
    expect_out(SEL_SIDE, 0);
    expect_out(SEL_DBG, 0);
  endtask

  // Runs n sweep edges; busy must stay 1 for 32 observations after reset
  // and drop on the 32nd edge. With inject set, writes are attempted mid-sweep.
  task automatic sweep(input int n, input bit inject);
    for (int k = 1; k <= n; k++) begin
      side_in  = 4'h3;
      set_rd(7, 2);
      dbg_addr = 7;
      wr_en    = inject && (k == 5 || k == 20);
      wr_addr  = (k == 5) ? ADDR_W'(7) : ADDR_W'(2);
      wr_data  = 32'hAAAA5555;
      step();
      expect_out(SEL_BUSY, (k < 32) ? 1 : 0);
      expect_out(SEL_SIDE, 0);
      expect_out(SEL_RD0, 0);
      expect_out(SEL_DBG, 0);
    end
    wr_en   = 0;
    side_in = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; stall = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr = 0; side_in = 0; dbg_addr = 0;
    step();
    step();
    reset = 0;
    expect_reset_state();

    // Full clear sweep with writes that must be ignored.
    sweep(32, 1'b1);

    // Every register reads zero after the sweep.
    for (int a = 0; a < 32; a += 2) begin
      set_rd(a, a + 1);
      dbg_addr = ADDR_W'(a);
      step();
      expect_out(SEL_RD0, 0);
      expect_out(SEL_RD1, 0);
      expect_out(SEL_DBG, 0);
    end

    // r5 write, both ports read it back.
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 0;
    set_rd(5, 5);
    step();
    expect_out(SEL_RD0, 32'hDEADBEEF);
    expect_out(SEL_RD1, 32'hDEADBEEF);

    // x0 write is dropped.
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
    step();
    wr_en = 0;
    set_rd(0, 5);
    step();
    expect_out(SEL_RD0, 0);
    expect_out(SEL_RD1, 32'hDEADBEEF);

    // Same-edge write/read of r3 (previously 0x22).
    wr_en = 1; wr_addr = 3; wr_data = 32'h22;
    step();
    wr_data = 32'h11;
    set_rd(3, 3);
    step();
`ifdef REGFILE_BYPASS_EN
    expect_out(SEL_RD0, 32'h11);
    expect_out(SEL_RD1, 32'h11);
`else
    expect_out(SEL_RD0, 32'h22);
    expect_out(SEL_RD1, 32'h22);
`endif
    wr_en = 0;
    step();
    expect_out(SEL_RD0, 32'h11);

    // Same-edge x0 write never forwards.
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    set_rd(0, 0);
    step();
    wr_en = 0;
    expect_out(SEL_RD0, 0);
    expect_out(SEL_RD1, 0);

    // Stall: load known outputs, then hold for 3 cycles.
    set_rd(5, 3);
    side_in = 4'h5;
    step();
    expect_out(SEL_RD0, 32'hDEADBEEF);
    expect_out(SEL_RD1, 32'h11);
    expect_out(SEL_SIDE, 4'h5);

    stall = 1;
    set_rd(3, 9);
    side_in = 4'hA;
    for (int s = 0; s < 3; s++) begin
      wr_en    = (s == 0);
      wr_addr  = 9;
      wr_data  = 32'h99;
      dbg_addr = (s == 0) ? ADDR_W'(5) : (s == 1) ? ADDR_W'(9) : ADDR_W'(0);
      step();
      expect_out(SEL_RD0, 32'hDEADBEEF);
      expect_out(SEL_RD1, 32'h11);
      expect_out(SEL_SIDE, 4'h5);
      expect_out(SEL_DBG, (s == 0) ? 32'hDEADBEEF : (s == 1) ? 32'h99 : 32'h0);
    end
    wr_en = 0;
    stall = 0;
    step();
    expect_out(SEL_RD0, 32'h11);
    expect_out(SEL_RD1, 32'h99);
    expect_out(SEL_SIDE, 4'hA);

    // Reset, then reset again 10 cycles into the sweep.
    reset = 1;
    step();
    reset = 0;
    side_in = 0;
    expect_reset_state();
    sweep(10, 1'b0);
    reset = 1;
    step();
    reset = 0;
    expect_reset_state();
    sweep(32, 1'b0);

    // Storage was cleared by the new sweep.
    set_rd(5, 9);
    dbg_addr = 3;
    step();
    expect_out(SEL_RD0, 0);
    expect_out(SEL_RD1, 0);
    expect_out(SEL_DBG, 0);

    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
